// File: rtl/mc_sequencer_pkg.sv
// Shared types and encodings for the multicycle sequencer and its decoder.
// Pure declarations: no latency, no flow control.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_FETCH2, S_MEM_RD, S_WB_LD, S_MEM_WR,
    S_JUMP, S_EXEC, S_WB_ALU, S_WB_MOV, S_HALT, S_FAULT
  } state_t;

  typedef enum logic [2:0] {
    CLS_MREF, CLS_ALU, CLS_CMP, CLS_MOV, CLS_NOP, CLS_HALT
  } iclass_t;

  localparam logic [1:0] MREF_LDA = 2'b00;
  localparam logic [1:0] MREF_STA = 2'b01;
  localparam logic [1:0] MREF_JMP = 2'b10;
  localparam logic [1:0] MREF_JZ  = 2'b11;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  localparam logic [1:0] RF_WSEL_TR  = 2'b00;
  localparam logic [1:0] RF_WSEL_REG = 2'b01;
  localparam logic [1:0] RF_WSEL_ALU = 2'b10;

endpackage

// File: rtl/mc_sequencer_if.sv
// Sequencer <-> datapath/memory control bundle; master = sequencer, slave = datapath.
// Wires only: no latency; memory backpressure via mem_ready.
interface mc_if;
  logic [7:0] ir;
  logic [2:0] czn;
  logic       mem_ready;
  logic       mem_read;
  logic       mem_write;
  logic       mem_adr_sel;
  logic       pc_ld;
  logic       pc_src_sel;
  logic       ir_ld;
  logic       tr_ld;
  logic       alu_ld;
  logic [1:0] alu_op;
  logic       czn_ld;
  logic       rf_we;
  logic [1:0] rf_wsel;
  logic       halted;
  logic       fault;

  modport master (
    input  ir, czn, mem_ready,
    output mem_read, mem_write, mem_adr_sel, pc_ld, pc_src_sel, ir_ld, tr_ld,
           alu_ld, alu_op, czn_ld, rf_we, rf_wsel, halted, fault
  );

  modport slave (
    output ir, czn, mem_ready,
    input  mem_read, mem_write, mem_adr_sel, pc_ld, pc_src_sel, ir_ld, tr_ld,
           alu_ld, alu_op, czn_ld, rf_we, rf_wsel, halted, fault
  );
endinterface

// File: rtl/mc_sequencer_decode.sv
// Instruction decoder: IR -> instruction class, ALU op, memory-reference op.
// Combinational, zero latency, no flow control.
module mc_decode
  import mc_pkg::*;
(
  input  logic [7:0] ir,
  output iclass_t    cls,
  output logic [1:0] alu_op,
  output logic [1:0] mref_op
);

  always_comb begin
    cls     = CLS_NOP;
    alu_op  = ALU_ADD;
    mref_op = ir[6:5];
    if (!ir[7]) begin
      cls = CLS_MREF;
    end else if (!ir[6]) begin
      cls    = CLS_ALU;
      alu_op = ir[5:4];
    end else begin
      case (ir[5:4])
        2'b00:   cls = CLS_MOV;
        2'b01: begin
          cls    = CLS_CMP;
          alu_op = ALU_SUB;
        end
        2'b10:   cls = CLS_NOP;
        default: cls = (ir[3:0] == 4'hF) ? CLS_HALT : CLS_NOP;
      endcase
    end
  end

endmodule

// File: rtl/mc_sequencer.sv
// Multicycle control FSM with mem_ready wait states, bounded stall timeout, sticky HALT/FAULT.
// Strobes are registered from next state; memory-completion loads (ir_ld/tr_ld/fetch pc_ld) follow mem_ready.
module mc_sequencer
  import mc_pkg::*;
#(
  parameter int WAIT_MAX = 8
) (
  input logic   clk,
  input logic   rst,
  mc_if.master  bus
);

  state_t     state, ns;
  iclass_t    cls;
  logic [1:0] dec_alu_op, mref_op;
  logic [7:0] wait_cnt;

  logic       mem_read_q, mem_write_q, adr_sel_q, pc_jmp_q, alu_ld_q, czn_ld_q, rf_we_q;
  logic       halted_q, fault_q;
  logic [1:0] alu_op_q, rf_wsel_q;
  logic       mem_act, done, stall;

  mc_decode u_decode (
    .ir      (bus.ir),
    .cls     (cls),
    .alu_op  (dec_alu_op),
    .mref_op (mref_op)
  );

  // A memory state only counts as an active access once its strobe is on the bus.
  assign mem_act = mem_read_q | mem_write_q;
  assign done    = mem_act & bus.mem_ready;
  assign stall   = mem_act & ~bus.mem_ready;

  always_comb begin
    ns = state;
    case (state)
      S_FETCH:  if (done) ns = S_DECODE;
      S_DECODE: begin
        case (cls)
          CLS_MREF:          ns = S_FETCH2;
          CLS_ALU, CLS_CMP:  ns = S_EXEC;
          CLS_MOV:           ns = S_WB_MOV;
          CLS_HALT:          ns = S_HALT;
          default:           ns = S_FETCH;
        endcase
      end
      S_FETCH2: begin
        if (done) begin
          case (mref_op)
            MREF_LDA: ns = S_MEM_RD;
            MREF_STA: ns = S_MEM_WR;
            MREF_JMP: ns = S_JUMP;
            default:  ns = bus.czn[1] ? S_JUMP : S_FETCH;
          endcase
        end
      end
      S_MEM_RD: if (done) ns = S_WB_LD;
      S_MEM_WR: if (done) ns = S_FETCH;
      S_EXEC:   ns = (cls == CLS_CMP) ? S_FETCH : S_WB_ALU;
      S_WB_LD, S_WB_ALU, S_WB_MOV, S_JUMP: ns = S_FETCH;
      default:  ns = state;
    endcase
    if (stall && wait_cnt == 8'(WAIT_MAX))
      ns = S_FAULT;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_FETCH;
      wait_cnt    <= 8'd0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      adr_sel_q   <= 1'b0;
      pc_jmp_q    <= 1'b0;
      alu_ld_q    <= 1'b0;
      czn_ld_q    <= 1'b0;
      alu_op_q    <= ALU_ADD;
      rf_we_q     <= 1'b0;
      rf_wsel_q   <= RF_WSEL_TR;
      halted_q    <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state       <= ns;
      wait_cnt    <= (stall && ns == state) ? wait_cnt + 8'd1 : 8'd0;
      mem_read_q  <= (ns == S_FETCH) || (ns == S_FETCH2) || (ns == S_MEM_RD);
      mem_write_q <= (ns == S_MEM_WR);
      adr_sel_q   <= (ns == S_MEM_RD) || (ns == S_MEM_WR);
      pc_jmp_q    <= (ns == S_JUMP);
      alu_ld_q    <= (ns == S_EXEC);
      czn_ld_q    <= (ns == S_EXEC);
      alu_op_q    <= (ns == S_EXEC) ? dec_alu_op : ALU_ADD;
      rf_we_q     <= (ns == S_WB_LD) || (ns == S_WB_ALU) || (ns == S_WB_MOV);
      rf_wsel_q   <= (ns == S_WB_ALU) ? RF_WSEL_ALU :
                     (ns == S_WB_MOV) ? RF_WSEL_REG : RF_WSEL_TR;
      halted_q    <= (ns == S_HALT);
      fault_q     <= (ns == S_FAULT);
    end
  end

  // Load/write strobes are masked during reset so a racing mem_ready cannot commit anything.
  assign bus.mem_read    = mem_read_q;
  assign bus.mem_write   = mem_write_q;
  assign bus.mem_adr_sel = adr_sel_q;
  assign bus.pc_src_sel  = pc_jmp_q;
  assign bus.ir_ld       = ~rst & done & (state == S_FETCH);
  assign bus.tr_ld       = ~rst & done & ((state == S_FETCH2) || (state == S_MEM_RD));
  assign bus.pc_ld       = ~rst & (pc_jmp_q | (done & ((state == S_FETCH) || (state == S_FETCH2))));
  assign bus.alu_ld      = ~rst & alu_ld_q;
  assign bus.czn_ld      = ~rst & czn_ld_q;
  assign bus.alu_op      = alu_op_q;
  assign bus.rf_we       = ~rst & rf_we_q;
  assign bus.rf_wsel     = rf_wsel_q;
  assign bus.halted      = halted_q;
  assign bus.fault       = fault_q;

endmodule

// File: tb/tb_mc_sequencer.sv
// Directed bench for mc_sequencer: per-cycle strobe vectors checked against hand-computed values.
module tb_mc_sequencer;

  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0;
  int   n_err = 0;

  mc_if bus ();

  mc_sequencer #(.WAIT_MAX(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Observation vector bit masks
  localparam logic [15:0] RD     = 16'h8000;
  localparam logic [15:0] WR     = 16'h4000;
  localparam logic [15:0] ADR    = 16'h2000;
  localparam logic [15:0] PCLD   = 16'h1000;
  localparam logic [15:0] PCSRC  = 16'h0800;
  localparam logic [15:0] IRLD   = 16'h0400;
  localparam logic [15:0] TRLD   = 16'h0200;
  localparam logic [15:0] ALULD  = 16'h0100;
  localparam logic [15:0] OP_SUB = 16'h0040;
  localparam logic [15:0] OP_OR  = 16'h00C0;
  localparam logic [15:0] CZNLD  = 16'h0020;
  localparam logic [15:0] RFWE   = 16'h0010;
  localparam logic [15:0] WS_REG = 16'h0004;
  localparam logic [15:0] WS_ALU = 16'h0008;
  localparam logic [15:0] HALT   = 16'h0002;
  localparam logic [15:0] FAULT  = 16'h0001;
  localparam logic [15:0] FD     = RD | IRLD | PCLD;

  function automatic logic [15:0] obs();
    return {bus.mem_read, bus.mem_write, bus.mem_adr_sel, bus.pc_ld, bus.pc_src_sel,
            bus.ir_ld, bus.tr_ld, bus.alu_ld, bus.alu_op, bus.czn_ld, bus.rf_we,
            bus.rf_wsel, bus.halted, bus.fault};
  endfunction

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock, apply mem_ready for the new cycle, then sample.
  task automatic step(input string tag, input logic rdy, input logic [15:0] exp);
    @(posedge clk);
    #1;
    bus.mem_ready = rdy;
    #1;
    chk(tag, obs(), exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    bus.mem_ready = 1'b0;
    bus.ir  = 8'h00;
    bus.czn = 3'b000;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0; #1;
    chk("reset", obs(), 16'h0000);

    // ADD R1,R2
    bus.ir = 8'h86;
    step("add_fetch", 1'b1, FD);
    step("add_dec",   1'b1, 16'h0000);
    step("add_exec",  1'b1, ALULD | CZNLD);
    step("add_wb",    1'b1, RFWE | WS_ALU);
    step("add_next",  1'b1, FD);

    // OR R1,R0
    bus.ir = 8'hB4;
    step("or_dec",  1'b1, 16'h0000);
    step("or_exec", 1'b1, ALULD | CZNLD | OP_OR);
    step("or_wb",   1'b1, RFWE | WS_ALU);
    step("or_next", 1'b1, FD);

    // JZ taken
    bus.ir = 8'h60; bus.czn = 3'b010;
    step("jzt_dec",  1'b1, 16'h0000);
    step("jzt_f2",   1'b1, RD | TRLD | PCLD);
    step("jzt_jump", 1'b1, PCLD | PCSRC);
    step("jzt_next", 1'b1, FD);

    // JZ not taken
    bus.czn = 3'b000;
    step("jzn_dec",  1'b1, 16'h0000);
    step("jzn_f2",   1'b1, RD | TRLD | PCLD);
    step("jzn_next", 1'b1, FD);

    // 0xF3 behaves as NOP
    bus.ir = 8'hF3;
    step("nop_dec",  1'b1, 16'h0000);
    step("nop_next", 1'b1, FD);

    // STA with three stalled cycles
    bus.ir = 8'h20;
    step("sta_dec", 1'b1, 16'h0000);
    step("sta_f2",  1'b1, RD | TRLD | PCLD);
    step("sta_w1",  1'b0, WR | ADR);
    step("sta_w2",  1'b0, WR | ADR);
    step("sta_w3",  1'b0, WR | ADR);
    step("sta_w4",  1'b1, WR | ADR);
    step("sta_next", 1'b1, FD);

    // Reset held two cycles in the middle of FETCH2
    bus.ir = 8'h00;
    step("rst_dec", 1'b1, 16'h0000);
    step("rst_f2",  1'b1, RD | TRLD | PCLD);
    rst = 1'b1; #1;
    chk("rst_mask", obs(), RD);
    @(posedge clk); #2;
    chk("rst_hold", obs(), 16'h0000);
    @(posedge clk); #1; rst = 1'b0; #1;
    chk("rst_out", obs(), 16'h0000);
    step("rst_fetch", 1'b1, FD);

    // LDA
    step("lda_dec",  1'b1, 16'h0000);
    step("lda_f2",   1'b1, RD | TRLD | PCLD);
    step("lda_mrd",  1'b1, RD | ADR | TRLD);
    step("lda_wb",   1'b1, RFWE);
    step("lda_next", 1'b1, FD);

    // MOV R1,R2
    bus.ir = 8'hC6;
    step("mov_dec",  1'b1, 16'h0000);
    step("mov_wb",   1'b1, RFWE | WS_REG);
    step("mov_next", 1'b1, FD);

    // CMP
    bus.ir = 8'hD1;
    step("cmp_dec",  1'b1, 16'h0000);
    step("cmp_exec", 1'b1, ALULD | CZNLD | OP_SUB);
    step("cmp_next", 1'b1, FD);

    // Fetch stalls: ready on the last allowed cycle, then a real timeout
    bus.ir = 8'hE0;
    step("nop2_dec", 1'b1, 16'h0000);
    for (int i = 0; i < 4; i++) step("stall_ok", 1'b0, RD);
    step("stall_last", 1'b1, FD);
    step("nofault_dec", 1'b1, 16'h0000);
    for (int i = 0; i < 5; i++) step("hang", 1'b0, RD);
    step("fault", 1'b0, FAULT);
    for (int i = 0; i < 3; i++) step("fault_sticky", 1'b1, FAULT);

    // HALT
    rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0; #1;
    chk("rst2", obs(), 16'h0000);
    bus.ir = 8'hFF;
    step("halt_fetch", 1'b1, FD);
    step("halt_dec",   1'b1, 16'h0000);
    step("halted",     1'b1, HALT);
    for (int i = 0; i < 3; i++) step("halt_sticky", 1'b1, HALT);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
